// File: rtl/adder_pkg.sv
// Shared constants for the pipelined carry-lookahead adder: op encodings and the
// elaboration-time legality rule for the N / G / STAGES parameter combination.
package adder_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Each pipeline slice must hold a whole number of lookahead groups.
   function automatic bit cfg_legal(input int n, input int g, input int stages);
      return (n > 0) && (g > 0) && (stages >= 1) &&
             ((n % g) == 0) && ((n % (stages * g)) == 0);
   endfunction

endpackage

// File: rtl/cla_group.sv
// G-bit carry-lookahead group: every internal carry is a flat sum of products of
// generate/propagate terms, plus group generate/propagate for the next level.
module cla_group
   import adder_pkg::*;
#(
   parameter int G = 4
) (
   input  logic [G-1:0] a_i,
   input  logic [G-1:0] b_i,
   input  logic         cin_i,
   output logic [G-1:0] sum_o,
   output logic         gg_o,
   output logic         gp_o
);

   logic [G-1:0] g;
   logic [G-1:0] p;
   logic [G-1:0] c;
   logic         term;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   // c[i] = p[i-1..0]&cin | OR_j ( g[j] & p[i-1..j+1] ), expanded for each bit
   always_comb begin
      c    = '0;
      gg_o = 1'b0;
      term = 1'b0;
      for (int i = 0; i < G; i++) begin
         term = cin_i;
         for (int j = 0; j < i; j++) term = term & p[j];
         c[i] = term;
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int m = j + 1; m < i; m++) term = term & p[m];
            c[i] = c[i] | term;
         end
      end
      for (int j = 0; j < G; j++) begin
         term = g[j];
         for (int m = j + 1; m < G; m++) term = term & p[m];
         gg_o = gg_o | term;
      end
   end

   assign gp_o  = &p;
   assign sum_o = p ^ c;

endmodule

// File: rtl/pipelined_cla_adder.sv
// STAGES-deep add/subtract pipeline, one N/STAGES-bit CLA slice per stage, valid/ready
// on both ends. Define PIPELINED_CLA_ADDER_SAT_EN to saturate s on signed overflow.
module pipelined_cla_adder
   import adder_pkg::*;
#(
   parameter int N      = 32,
   parameter int G      = 4,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] s,
   output logic         cout,
   output logic         ovf
);

   localparam int W   = N / STAGES;
   localparam int GPS = W / G;
   localparam int L   = STAGES - 1;

   if (!cfg_legal(N, G, STAGES)) begin : g_bad_cfg
      $error("pipelined_cla_adder: illegal N/G/STAGES combination");
   end

   // Stage k register: effective operands, sum bits of slices 0..k, carry out of slice k.
   logic [N-1:0] a_q [STAGES];
   logic [N-1:0] b_q [STAGES];
   logic [N-1:0] s_q [STAGES];
   logic         c_q [STAGES];
   logic         v_q [STAGES];
   logic         ovf_q;

   logic [N-1:0] a_in [STAGES];
   logic [N-1:0] b_in [STAGES];
   logic [N-1:0] s_in [STAGES];
   logic [N-1:0] s_d  [STAGES];
   logic         c_in [STAGES];
   logic         c_d  [STAGES];
   logic         v_in [STAGES];
   logic         adv;

   // Whole pipeline advances unless the held result is being refused.
   assign adv      = !(v_q[L] && !out_ready);
   assign in_ready = adv;

   assign a_in[0] = a;
   assign b_in[0] = (sub == OP_SUB) ? ~b : b;
   assign c_in[0] = (sub == OP_SUB) ? 1'b1 : cin;
   assign s_in[0] = '0;
   assign v_in[0] = in_valid;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [GPS:0]   gc;
      logic [GPS-1:0] gg;
      logic [GPS-1:0] gp;
      logic [W-1:0]   slice_s;

      if (k > 0) begin : g_link
         assign a_in[k] = a_q[k-1];
         assign b_in[k] = b_q[k-1];
         assign s_in[k] = s_q[k-1];
         assign c_in[k] = c_q[k-1];
         assign v_in[k] = v_q[k-1];
      end

      assign gc[0] = c_in[k];
      for (genvar j = 0; j < GPS; j++) begin : g_grp
         cla_group #(.G(G)) u_grp (
            .a_i   (a_in[k][k*W + j*G +: G]),
            .b_i   (b_in[k][k*W + j*G +: G]),
            .cin_i (gc[j]),
            .sum_o (slice_s[j*G +: G]),
            .gg_o  (gg[j]),
            .gp_o  (gp[j])
         );
         assign gc[j+1] = gg[j] | (gp[j] & gc[j]);
      end

      // Upper slices are still zero here, so OR-ing in this slice places it.
      assign s_d[k] = s_in[k] | (N'(slice_s) << (k * W));
      assign c_d[k] = gc[GPS];
   end

   logic [N-1:0] s_raw;
   logic [N-1:0] s_fin;
   logic         sign_a;
   logic         sign_b;
   logic         ovf_d;

   assign s_raw  = s_d[L];
   assign sign_a = a_in[L][N-1];
   assign sign_b = b_in[L][N-1];
   assign ovf_d  = (sign_a == sign_b) && (s_raw[N-1] != sign_a);

`ifdef PIPELINED_CLA_ADDER_SAT_EN
   assign s_fin = !ovf_d ? s_raw :
                  sign_a ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`else
   assign s_fin = s_raw;
`endif

   // Payload loads only with a valid transfer so bubbles leave s/cout/ovf untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= v_in[k];
            if (v_in[k]) begin
               a_q[k] <= a_in[k];
               b_q[k] <= b_in[k];
               s_q[k] <= (k == L) ? s_fin : s_d[k];
               c_q[k] <= c_d[k];
            end
         end
         if (v_in[L]) ovf_q <= ovf_d;
      end
   end

   assign out_valid = v_q[L];
   assign s         = s_q[L];
   assign cout      = c_q[L];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed cases on an 8-bit, 2-stage instance and
// random traffic on 32-bit instances with STAGES = 1, 2, 4.
module tb_pipelined_cla_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic rrst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   out_cnt = 0;
   int   rnd_done_cnt = 0;
   int   c0;

`ifdef PIPELINED_CLA_ADDER_SAT_EN
   localparam logic [7:0] OVF_S = 8'h7F;
`else
   localparam logic [7:0] OVF_S = 8'h80;
`endif

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Returns {ovf, cout, s} with s in the low n bits.
   function automatic logic [33:0] ref_model(input int n, input logic [31:0] fa,
                                             input logic [31:0] fb, input logic fcin,
                                             input logic fsub);
      logic [31:0] mask, be, res;
      logic [32:0] sum;
      logic        sa, sb, ov, co;
      mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      be   = (fsub ? ~fb : fb) & mask;
      sum  = {1'b0, fa & mask} + {1'b0, be} + {32'd0, (fsub ? 1'b1 : fcin)};
      co   = sum[n];
      res  = sum[31:0] & mask;
      sa   = fa[n-1];
      sb   = be[n-1];
      ov   = (sa == sb) && (res[n-1] != sa);
`ifdef PIPELINED_CLA_ADDER_SAT_EN
      if (ov) res = sa ? (32'd1 << (n-1)) : (mask >> 1);
`endif
      return {ov, co, res};
   endfunction

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 7))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- directed 8-bit instance ----------------
   logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [7:0] a, b, s;
   logic [33:0] exp_q[$];

   pipelined_cla_adder #(.N(8), .G(4), .STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .cout(cout), .ovf(ovf)
   );

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            out_cnt++;
            check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0)
               check("sb_result", {30'd0, ovf, cout, 24'd0, s}, {30'd0, exp_q.pop_front()});
         end
         if (in_valid && in_ready)
            exp_q.push_back(ref_model(8, {24'd0, a}, {24'd0, b}, cin, sub));
      end
   end

   // Holds the transfer until accepted (or the wait bound expires).
   task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input logic ts);
      logic acc;
      int   tries;
      a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
         @(negedge clk);
         acc = in_ready;
         tries++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("send_accept", 64'(acc), 64'd1);
   endtask

   // ---------------- random 32-bit instances ----------------
   for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
      localparam int ST = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
      logic        r_in_valid, r_in_ready, r_cin, r_sub, r_out_valid, r_out_ready, r_cout, r_ovf;
      logic [31:0] r_a, r_b, r_s;
      logic [33:0] q[$];
      logic        acc = 1'b0;

      pipelined_cla_adder #(.N(32), .G(4), .STAGES(ST)) u_rdut (
         .clk(clk), .rst(rrst), .in_valid(r_in_valid), .in_ready(r_in_ready),
         .a(r_a), .b(r_b), .cin(r_cin), .sub(r_sub),
         .out_valid(r_out_valid), .out_ready(r_out_ready),
         .s(r_s), .cout(r_cout), .ovf(r_ovf)
      );

      always @(negedge clk) begin
         acc = 1'b0;
         if (rrst) begin
            q.delete();
         end else begin
            if (r_out_valid && r_out_ready) begin
               check("rnd_nonempty", 64'(q.size() > 0), 64'd1);
               if (q.size() > 0)
                  check($sformatf("rnd_st%0d", ST), {30'd0, r_ovf, r_cout, r_s}, {30'd0, q.pop_front()});
            end
            if (r_in_valid && r_in_ready) begin
               q.push_back(ref_model(32, r_a, r_b, r_cin, r_sub));
               acc = 1'b1;
            end
         end
      end

      initial begin
         r_in_valid = 1'b0; r_a = '0; r_b = '0; r_cin = 1'b0; r_sub = 1'b0; r_out_ready = 1'b1;
         wait (rrst == 1'b0);
         tick(1);
         for (int c = 0; c < 600; c++) begin
            if (!r_in_valid || acc) begin
               r_in_valid = ($urandom_range(0, 3) != 0);
               r_a   = rnd_word();
               r_b   = rnd_word();
               r_cin = 1'($urandom_range(0, 1));
               r_sub = 1'($urandom_range(0, 1));
            end
            r_out_ready = ($urandom_range(0, 3) != 0);
            tick(1);
         end
         r_out_ready = 1'b1;
         for (int w = 0; w < 8 && r_in_valid && !acc; w++) tick(1);
         r_in_valid = 1'b0;
         tick(ST + 4);
         check($sformatf("rnd_drain_st%0d", ST), 64'(q.size()), 64'd0);
         rnd_done_cnt++;
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rrst = 1'b0;
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      tick(2);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_s", 64'(s), 64'd0);
      check("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      tick(1);

      // signed overflow and two-cycle latency
      send(8'h7F, 8'h01, 1'b0, 1'b0);
      check("lat_early", 64'(out_valid), 64'd0);
      tick(1);
      check("lat_valid", 64'(out_valid), 64'd1);
      check("ovf_case", 64'({ovf, cout, s}), 64'({2'b10, OVF_S}));

      // subtract ignores cin; full-carry add
      send(8'h05, 8'h07, 1'b1, 1'b1);
      tick(1);
      check("sub_case", 64'({ovf, cout, s}), 64'({2'b00, 8'hFE}));
      send(8'hFF, 8'hFF, 1'b1, 1'b0);
      tick(1);
      check("cin_case", 64'({ovf, cout, s}), 64'({2'b01, 8'hFF}));
      tick(2);

      // four back-to-back transfers
      c0 = out_cnt;
      for (int i = 0; i < 4; i++) send(8'(16 * i + 3), 8'(37 * i), i[0], i[1]);
      check("b2b_v3", 64'(out_valid), 64'd1);
      tick(1);
      check("b2b_v4", 64'(out_valid), 64'd1);
      tick(1);
      check("b2b_idle", 64'(out_valid), 64'd0);
      check("b2b_count", 64'(out_cnt - c0), 64'd4);

      // stall with full pipeline
      out_ready = 1'b0;
      c0 = out_cnt;
      send(8'h11, 8'h22, 1'b0, 1'b0);
      send(8'h33, 8'h44, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_s", 64'(s), 64'h33);
         tick(1);
      end
      out_ready = 1'b1;
      tick(3);
      check("stall_count", 64'(out_cnt - c0), 64'd2);
      check("stall_q_empty", 64'(exp_q.size()), 64'd0);

      // reset with two transfers in flight
      send(8'h21, 8'h43, 1'b0, 1'b0);
      send(8'h65, 8'h87, 1'b0, 1'b1);
      rst = 1'b1;
      tick(1);
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_s", 64'({ovf, cout, s}), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      c0 = out_cnt;
      send(8'h12, 8'h34, 1'b0, 1'b0);
      tick(4);
      check("flush_one", 64'(out_cnt - c0), 64'd1);
      check("flush_q_empty", 64'(exp_q.size()), 64'd0);

      for (int w = 0; w < 5000 && rnd_done_cnt < 3; w++) @(posedge clk);
      check("rnd_all_done", 64'(rnd_done_cnt), 64'd3);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
